// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg : shared state encoding and limits for the TDM bus master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } tdm_master_state_t;

  localparam int SLOT_SCK_DEFAULT = 32;
  localparam int MIN_HALF_PERIOD  = 2;

endpackage

`default_nettype wire

// File: rtl/tdm_bus_master_if.sv
// ---------------------------------------------------------------------------
// tdm_bus_master_if : control/config inputs and TDM bus outputs of the master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tdm_bus_master_if #(
  parameter int DIV_W  = 8,
  parameter int WARM_W = 16
);

  logic              enable_in;
  logic [DIV_W-1:0]  half_period_in;
  logic [WARM_W-1:0] warmup_frames_in;
  logic              audio_valid_in;
  logic              sck_out;
  logic              ws_out;
  logic              frame_start_out;
  logic              running_out;
  logic              data_ready_out;
  logic              missed_frame_out;
  logic [15:0]       error_count_out;

  modport master (
    input  enable_in, half_period_in, warmup_frames_in, audio_valid_in,
    output sck_out, ws_out, frame_start_out, running_out, data_ready_out,
           missed_frame_out, error_count_out
  );

  modport slave (
    output enable_in, half_period_in, warmup_frames_in, audio_valid_in,
    input  sck_out, ws_out, frame_start_out, running_out, data_ready_out,
           missed_frame_out, error_count_out
  );

endinterface

`default_nettype wire

// File: rtl/tdm_sck_divider.sv
// ---------------------------------------------------------------------------
// tdm_sck_divider : sck generator, toggles every hp clk_in cycles while run
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_sck_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             run,
  input  logic [DIV_W-1:0] hp,
  output logic             sck_out,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             toggle;

  assign toggle = run && (div_cnt_q == hp - DIV_W'(1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    if (!run) begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
    end else if (toggle) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  // Pulses flag the cycle whose closing edge performs the toggle
  assign rise_pulse = toggle && !sck_q;
  assign fall_pulse = toggle && sck_q;
  assign sck_out    = sck_q;

endmodule

`default_nettype wire

// File: rtl/tdm_bus_master.sv
// ---------------------------------------------------------------------------
// tdm_bus_master : TDM sck/ws master with warm-up gating and frame monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_bus_master
  import tdm_pkg::*;
#(
  parameter int SLOTS     = 4,
  parameter int SLOT_SCK  = SLOT_SCK_DEFAULT,
  parameter int FRAME_SCK = SLOTS * SLOT_SCK,
  parameter int DIV_W     = 8,
  parameter int WARM_W    = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  tdm_bus_master_if.master  bus
);

  localparam int                BIT_W    = $clog2(FRAME_SCK);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_SCK - 1);
  localparam logic [DIV_W-1:0]  HP_MIN   = DIV_W'(MIN_HALF_PERIOD);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WARMUP   = WARMUP;
  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_STOPPING = STOPPING;

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  hp_q, hp_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ws_q, ws_d;
  logic              frame_start_q, frame_start_d;
  logic [1:0]        valid_cnt_q, valid_cnt_d;
  logic              first_q, first_d;
  logic              missed_q, missed_d;
  logic [15:0]       err_q, err_d;

  logic run;
  logic sck;
  logic fall_pulse;
  logic sck_rise_unused;
  logic boundary;

  assign run      = (state_q != ST_IDLE);
  assign boundary = fall_pulse && (bit_cnt_q == LAST_BIT);

  tdm_sck_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .run        (run),
    .hp         (hp_q),
    .sck_out    (sck),
    .rise_pulse (sck_rise_unused),
    .fall_pulse (fall_pulse)
  );

  always_comb begin
    state_d       = state_q;
    hp_d          = hp_q;
    warm_d        = warm_q;
    warm_cnt_d    = warm_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    ws_d          = ws_q;
    valid_cnt_d   = valid_cnt_q;
    first_d       = first_q;
    err_d         = err_q;
    missed_d      = 1'b0;
    frame_start_d = boundary;

    // ws follows the counter, so it only moves on a falling sck toggle
    if (fall_pulse) begin
      bit_cnt_d = boundary ? '0 : bit_cnt_q + BIT_W'(1);
      ws_d      = (bit_cnt_d == LAST_BIT);
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d   = '0;
        ws_d        = 1'b0;
        warm_cnt_d  = '0;
        valid_cnt_d = '0;
        if (bus.enable_in) begin
          hp_d    = (bus.half_period_in < HP_MIN) ? HP_MIN : bus.half_period_in;
          warm_d  = bus.warmup_frames_in;
          first_d = 1'b1;
          state_d = (bus.warmup_frames_in == '0) ? ST_RUN : ST_WARMUP;
        end
      end

      ST_WARMUP: begin
        if (!bus.enable_in) begin
          state_d = ST_STOPPING;
        end else if (boundary) begin
          if (warm_cnt_q + WARM_W'(1) == warm_q) begin
            state_d     = ST_RUN;
            first_d     = 1'b1;
            valid_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
          end
        end
      end

      ST_RUN: begin
        if (boundary) begin
          if (!first_q && valid_cnt_q != 2'd1) begin
            missed_d = 1'b1;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
          first_d = 1'b0;
          // A strobe on the boundary cycle belongs to the frame just starting
          valid_cnt_d = {1'b0, bus.audio_valid_in};
        end else if (bus.audio_valid_in && valid_cnt_q != 2'd3) begin
          valid_cnt_d = valid_cnt_q + 2'd1;
        end
        if (!bus.enable_in) state_d = ST_STOPPING;
      end

      ST_STOPPING: begin
        if (boundary) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      hp_q          <= HP_MIN;
      warm_q        <= '0;
      warm_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      ws_q          <= 1'b0;
      frame_start_q <= 1'b0;
      valid_cnt_q   <= '0;
      first_q       <= 1'b0;
      missed_q      <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      hp_q          <= hp_d;
      warm_q        <= warm_d;
      warm_cnt_q    <= warm_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      ws_q          <= ws_d;
      frame_start_q <= frame_start_d;
      valid_cnt_q   <= valid_cnt_d;
      first_q       <= first_d;
      missed_q      <= missed_d;
      err_q         <= err_d;
    end
  end

  assign bus.sck_out          = sck;
  assign bus.ws_out           = ws_q;
  assign bus.frame_start_out  = frame_start_q;
  assign bus.running_out      = (state_q != ST_IDLE);
  assign bus.data_ready_out   = (state_q == ST_RUN);
  assign bus.missed_frame_out = missed_q;
  assign bus.error_count_out  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_bus_master.sv
// ---------------------------------------------------------------------------
// tb_tdm_bus_master : directed stimulus with a frame-boundary scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tdm_bus_master;

  typedef struct {
    int          cyc;
    logic        dr;
    logic        m;
    logic [15:0] e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdm_bus_master_if #(.DIV_W(8), .WARM_W(16)) bus ();

  tdm_bus_master #(
    .SLOTS    (4),
    .SLOT_SCK (32),
    .DIV_W    (8),
    .WARM_W   (16)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic dr, input logic m, input int e);
    exp_t x;
    x.cyc = c;
    x.dr  = dr;
    x.m   = m;
    x.e   = 16'(e);
    sb.push_back(x);
  endtask

  // Returns 1 ns after clock edge number c
  task automatic at_edge(input int c);
    int guard = 0;
    while (cyc < c && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic pulse_valid(input int c);
    at_edge(c - 1);
    bus.audio_valid_in = 1'b1;
    at_edge(c);
    bus.audio_valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sck"},     32'(bus.sck_out), 0);
    check({tag, "_ws"},      32'(bus.ws_out), 0);
    check({tag, "_fs"},      32'(bus.frame_start_out), 0);
    check({tag, "_running"}, 32'(bus.running_out), 0);
    check({tag, "_ready"},   32'(bus.data_ready_out), 0);
    check({tag, "_missed"},  32'(bus.missed_frame_out), 0);
    check({tag, "_errcnt"},  32'(bus.error_count_out), 0);
  endtask

  // Monitor: every frame_start pulse must match the next expected boundary
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.frame_start_out) begin
      if (sb.size() == 0) begin
        check("unexpected_frame_start", 1, 0);
      end else begin
        e = sb.pop_front();
        check("frame_cycle",   32'(cyc), 32'(e.cyc));
        check("frame_ready",   32'(bus.data_ready_out), 32'(e.dr));
        check("frame_missed",  32'(bus.missed_frame_out), 32'(e.m));
        check("frame_errcnt",  32'(bus.error_count_out), 32'(e.e));
      end
    end else if (bus.missed_frame_out) begin
      check("missed_off_boundary", 1, 0);
    end
  end

  initial begin
    int bad;
    bus.enable_in        = 1'b0;
    bus.half_period_in   = 8'd0;
    bus.warmup_frames_in = 16'd0;
    bus.audio_valid_in   = 1'b0;

    // Reset state
    at_edge(3);
    @(negedge clk);
    check_all_zero("reset");

    // hp=2, no warm-up: exit on edge 4, frames every 512 clk
    rst = 1'b0;
    bus.enable_in      = 1'b1;
    bus.half_period_in = 8'd2;
    push(516,  1'b1, 1'b0, 0);  // first RUN boundary is not checked
    push(1028, 1'b1, 1'b0, 0);  // one valid
    push(1540, 1'b1, 1'b1, 1);  // zero valids
    push(2052, 1'b1, 1'b1, 2);  // two valids
    push(2564, 1'b1, 1'b0, 2);  // one valid, another on the boundary
    push(3076, 1'b1, 1'b0, 2);  // only the boundary-cycle valid
    push(3588, 1'b0, 1'b0, 2);  // stop completes

    at_edge(5); @(negedge clk);
    check("sck_before_rise", 32'(bus.sck_out), 0);
    at_edge(6); @(negedge clk);
    check("sck_first_rise", 32'(bus.sck_out), 1);
    check("ready_no_warmup", 32'(bus.data_ready_out), 1);
    check("running_no_warmup", 32'(bus.running_out), 1);

    at_edge(511); @(negedge clk);
    check("ws_before", 32'(bus.ws_out), 0);
    at_edge(512); @(negedge clk);
    check("ws_rise", 32'(bus.ws_out), 1);
    at_edge(515); @(negedge clk);
    check("ws_hold", 32'(bus.ws_out), 1);
    at_edge(516); @(negedge clk);
    check("ws_fall", 32'(bus.ws_out), 0);

    pulse_valid(616);
    pulse_valid(1600);
    pulse_valid(1700);
    pulse_valid(2100);
    pulse_valid(2564);

    // Drop enable when bit_cnt reaches 40 in the frame starting at 3076
    at_edge(3236);
    bus.enable_in = 1'b0;
    at_edge(3240); @(negedge clk);
    check("stopping_ready", 32'(bus.data_ready_out), 0);
    check("stopping_running", 32'(bus.running_out), 1);

    at_edge(3589); @(negedge clk);
    check("idle_sck", 32'(bus.sck_out), 0);
    check("idle_running", 32'(bus.running_out), 0);
    bad = 0;
    for (int i = 3590; i < 4300; i++) begin
      at_edge(i); @(negedge clk);
      if (bus.ws_out !== 1'b0 || bus.sck_out !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 0);

    // hp=4, three warm-up frames: exit on edge 4401, frames every 1024 clk
    at_edge(4400);
    bus.half_period_in   = 8'd4;
    bus.warmup_frames_in = 16'd3;
    bus.enable_in        = 1'b1;
    push(5425, 1'b0, 1'b0, 2);
    push(6449, 1'b0, 1'b0, 2);
    push(7473, 1'b1, 1'b0, 2);
    push(8497, 1'b1, 1'b0, 2);

    at_edge(4404); @(negedge clk);
    check("hp4_sck_before_rise", 32'(bus.sck_out), 0);
    at_edge(4405); @(negedge clk);
    check("hp4_sck_first_rise", 32'(bus.sck_out), 1);
    check("warmup_running", 32'(bus.running_out), 1);
    check("warmup_ready", 32'(bus.data_ready_out), 0);
    at_edge(7472); @(negedge clk);
    check("ready_before_3rd", 32'(bus.data_ready_out), 0);
    at_edge(7473); @(negedge clk);
    check("ready_at_3rd", 32'(bus.data_ready_out), 1);

    // Mid-RUN reset, then restart with half_period_in = 0
    at_edge(8600);
    rst = 1'b1;
    bus.half_period_in   = 8'd0;
    bus.warmup_frames_in = 16'd0;
    at_edge(8601);
    rst = 1'b0;
    push(9114, 1'b1, 1'b0, 0);
    @(negedge clk);
    check_all_zero("midrun_reset");
    at_edge(8603); @(negedge clk);
    check("hp0_sck_before_rise", 32'(bus.sck_out), 0);
    at_edge(8604); @(negedge clk);
    check("hp0_sck_first_rise", 32'(bus.sck_out), 1);

    while (sb.size() != 0 && cyc < 9300) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
